spin_ctrl: RTL and testbench



---
 rtl/spin_ctrl_pkg.sv | 13 +
 rtl/spin_pos.sv | 40 ++++
 rtl/spin_ctrl.sv | 108 ++++++++++
 tb/tb_spin_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spin_ctrl_pkg.sv
// rtl/spin_ctrl_pkg.sv - shared state encodings and defaults for the LED spinner sequencer
package spin_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ADJUST   = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

    localparam int DEFAULT_SPEED_W = 4;

endpackage

// File: rtl/spin_pos.sv
// rtl/spin_pos.sv - LED position counter with up/down wrap and registered one-hot decode
module spin_pos #(
    parameter  int NUM_LEDS = 8,
    localparam int POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                advance,
    input  logic                dir,
    output logic [POS_W-1:0]    pos_o,
    output logic [NUM_LEDS-1:0] led_o
);

    localparam logic [POS_W-1:0] LAST = POS_W'(NUM_LEDS - 1);

    logic [POS_W-1:0] pos_next;

    always_comb begin
        pos_next = pos_o;
        if (advance) begin
            if (dir) begin
                pos_next = (pos_o == '0) ? LAST : pos_o - 1'b1;
            end else begin
                pos_next = (pos_o == LAST) ? '0 : pos_o + 1'b1;
            end
        end
    end

    // led_o is decoded from the next position so it changes on the same edge as pos_o
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_o <= '0;
            led_o <= NUM_LEDS'(1);
        end else begin
            pos_o <= pos_next;
            led_o <= NUM_LEDS'(1) << pos_next;
        end
    end

endmodule

// File: rtl/spin_ctrl.sv
// rtl/spin_ctrl.sv - spinner sequencer: start/stop FSM, ramped speed code, LED position advance
module spin_ctrl
    import spin_ctrl_pkg::*;
#(
    parameter  int NUM_LEDS   = 8,
    parameter  int SPEED_W    = DEFAULT_SPEED_W,
    parameter  int RAMP_TICKS = 4,
    localparam int POS_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                dir_i,
    input  logic [SPEED_W-1:0]  speed_tgt_i,
    input  logic                tick_i,
    output logic [SPEED_W-1:0]  speed_o,
    output logic [POS_W-1:0]    pos_o,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                running_o
);

    localparam int                RAMP_W    = $clog2(RAMP_TICKS) + 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

    state_t            state;
    logic [RAMP_W-1:0] ramp_cnt;
    logic              advance;
    logic              ramp_done;

    assign advance   = tick_i && (state != ST_IDLE);
    assign ramp_done = tick_i && (ramp_cnt == RAMP_LAST);

    spin_pos #(
        .NUM_LEDS (NUM_LEDS)
    ) u_pos (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .advance (advance),
        .dir     (dir_i),
        .pos_o   (pos_o),
        .led_o   (led_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            speed_o   <= '0;
            ramp_cnt  <= '0;
            running_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        state     <= ST_ADJUST;
                        ramp_cnt  <= '0;
                        running_o <= 1'b1;
                    end
                end
                ST_ADJUST: begin
                    if (stop_i) begin
                        state    <= ST_STOPPING;
                        ramp_cnt <= '0;
                    end else if (speed_o == speed_tgt_i) begin
                        state    <= ST_RUN;
                        ramp_cnt <= '0;
                    end else if (ramp_done) begin
                        // step direction follows the target as it is at this tick
                        ramp_cnt <= '0;
                        speed_o  <= (speed_o < speed_tgt_i) ? speed_o + 1'b1 : speed_o - 1'b1;
                    end else if (tick_i) begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop_i) begin
                        state    <= ST_STOPPING;
                        ramp_cnt <= '0;
                    end else if (speed_tgt_i != speed_o) begin
                        state    <= ST_ADJUST;
                        ramp_cnt <= '0;
                    end
                end
                ST_STOPPING: begin
                    if (start_i && !stop_i) begin
                        state    <= ST_ADJUST;
                        ramp_cnt <= '0;
                    end else if (ramp_done) begin
                        ramp_cnt <= '0;
                        if (speed_o == '0) begin
                            state     <= ST_IDLE;
                            running_o <= 1'b0;
                        end else begin
                            speed_o <= speed_o - 1'b1;
                        end
                    end else if (tick_i) begin
                        ramp_cnt <= ramp_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spin_ctrl.sv
// tb/tb_spin_ctrl.sv - scoreboard bench for spin_ctrl with directed vectors
module tb_spin_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] tgt = 4'd0;
    logic       tick = 1'b0;
    logic [3:0] speed;
    logic [2:0] pos;
    logic [7:0] led;
    logic       running;

    always #5 clk = ~clk;

    spin_ctrl #(
        .NUM_LEDS   (8),
        .SPEED_W    (4),
        .RAMP_TICKS (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .dir_i       (dir),
        .speed_tgt_i (tgt),
        .tick_i      (tick),
        .speed_o     (speed),
        .pos_o       (pos),
        .led_o       (led),
        .running_o   (running)
    );

    typedef struct {
        int         at;
        string      name;
        logic [3:0] speed;
        logic [2:0] pos;
        logic       running;
    } exp_t;

    exp_t q[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    always begin
        exp_t       e;
        logic [7:0] led_exp;
        @(posedge clk);
        edges = edges + 1;
        #1;
        while (q.size() > 0 && q[0].at <= edges) begin
            e       = q.pop_front();
            led_exp = 8'h01 << e.pos;
            checks  = checks + 1;
            if (e.at != edges || speed !== e.speed || pos !== e.pos ||
                led !== led_exp || running !== e.running) begin
                errors = errors + 1;
                $display("FAIL %s: got speed=%0d pos=%0d led=%h running=%0d, expected speed=%0d pos=%0d led=%h running=%0d",
                         e.name, speed, pos, led, running, e.speed, e.pos, led_exp, e.running);
            end
        end
    end

    task automatic step(input logic s, input logic p, input logic t, input logic d, input logic [3:0] g);
        @(negedge clk);
        start = s;
        stop  = p;
        tick  = t;
        dir   = d;
        tgt   = g;
    endtask

    task automatic chk(input string name, input int sp, input int ps, input logic run);
        exp_t e;
        e.at      = edges + 1;
        e.name    = name;
        e.speed   = 4'(sp);
        e.pos     = 3'(ps);
        e.running = run;
        q.push_back(e);
    endtask

    initial begin
        // 1: reset, ticks in IDLE are ignored
        step(0, 0, 0, 0, 0);
        chk("reset", 0, 0, 0);
        step(0, 0, 1, 0, 0);
        rst = 1'b0;
        chk("idle_tick", 0, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            step(0, 0, 1, 0, 0);
            chk("idle_tick", 0, 0, 0);
        end

        // 2: start, ramp up to 3 one code per two ticks
        step(1, 0, 0, 0, 3);
        chk("start", 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 1, 0, 3);
            chk("ramp_up", k / 2, k, 1);
        end
        step(0, 0, 0, 0, 3);
        chk("run", 3, 6, 1);

        // 3: stop with a tick in RUN moves pos but not the ramp counter
        step(0, 1, 1, 0, 3);
        chk("stop_tick", 3, 7, 1);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, 1, 0, 3);
            chk("ramp_down", 3 - k / 2, (7 + k) % 8, 1);
        end
        step(0, 0, 1, 0, 3);
        chk("stopped", 0, 7, 0);
        for (int k = 0; k < 2; k++) begin
            step(0, 0, 1, 0, 3);
            chk("idle_hold", 0, 7, 0);
        end

        // 4: wrap forward and reverse at speed 0
        step(1, 0, 0, 0, 0);
        chk("start0", 0, 7, 1);
        step(0, 0, 0, 0, 0);
        chk("run0", 0, 7, 1);
        step(0, 0, 1, 0, 0);
        chk("fwd_wrap", 0, 0, 1);
        step(0, 0, 1, 1, 0);
        chk("rev_wrap", 0, 7, 1);
        step(0, 0, 1, 0, 0);
        chk("fwd_wrap2", 0, 0, 1);

        // 5: retarget up, down, and reverse mid-ramp
        step(0, 0, 0, 0, 3);
        chk("retarget", 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 1, 0, 3);
            chk("ramp_up2", k / 2, k, 1);
        end
        step(0, 0, 0, 0, 3);
        chk("run3", 3, 6, 1);
        step(0, 0, 0, 0, 1);
        chk("tgt1", 3, 6, 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 1, 0, 1);
            chk("ramp_to1", 3 - k / 2, (6 + k) % 8, 1);
        end
        step(0, 0, 0, 0, 1);
        chk("run1", 1, 2, 1);
        step(0, 0, 0, 0, 15);
        chk("tgt15", 1, 2, 1);
        step(0, 0, 1, 0, 15);
        chk("up15_t1", 1, 3, 1);
        step(0, 0, 1, 0, 15);
        chk("up15_t2", 2, 4, 1);
        step(0, 0, 1, 0, 15);
        chk("up15_t3", 2, 5, 1);
        step(0, 0, 1, 0, 0);
        chk("retarget_down", 1, 6, 1);

        // 6: stop from ADJUST, start+stop together, start with tick, reset mid-ramp
        step(0, 1, 0, 0, 0);
        chk("stop_adj", 1, 6, 1);
        step(0, 0, 1, 0, 0);
        chk("stop_t1", 1, 7, 1);
        step(0, 0, 1, 0, 0);
        chk("stop_t2", 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("stop_t3", 0, 1, 1);
        step(0, 0, 1, 0, 0);
        chk("stop_t4", 0, 2, 0);
        step(1, 1, 0, 0, 5);
        chk("start_stop", 0, 2, 0);
        step(1, 0, 1, 0, 5);
        chk("start_tick", 0, 2, 1);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 1, 0, 5);
            chk("ramp_to5", k / 2, 2 + k, 1);
        end
        step(1, 0, 1, 0, 5);
        rst = 1'b1;
        chk("reset_mid", 0, 0, 0);
        step(0, 0, 1, 0, 5);
        rst = 1'b0;
        chk("post_reset", 0, 0, 0);

        step(0, 0, 0, 0, 0);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
